elevator_req_sched: RTL and testbench
=====================================

Name: elevator_req_sched

Overview:
- Request scheduler for the elevator car. Latches car-call and hall-call buttons and clears the requests that are served at each stop.
- Runs the travel-direction state machine with direction hysteresis.
- Feeds the car's state controller with the stop mask, up_need, down_need and direction mode.
- Sits between the button/lamp logic and the car state controller, in the same clk domain.

Parameters:
- FLOORS, 4, number of floors; width of every one-hot floor vector.

Ports:
- clk  input  1  system clock (32 Hz domain); all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- car_btn  input  FLOORS  car-panel floor buttons, level, already synchronised.
- hall_up  input  FLOORS  hall up-call buttons; bit FLOORS-1 is ignored.
- hall_dn  input  FLOORS  hall down-call buttons; bit 0 is ignored.
- position  input  FLOORS  one-hot current floor, from the car state controller.
- opendoor  input  1  door-open in progress, from the car state controller.
- mv2nxt  input  1  car moving between floors, from the car state controller.
- allReq_reg  output  FLOORS  stop mask: floors where the car must stop in the current direction.
- up_need  output  1  some pending request lies above position.
- down_need  output  1  some pending request lies below position.
- ud_mode  output  2  00 idle, 01 up, 10 down.
- car_lamp, up_lamp, dn_lamp  output  FLOORS each  mirrors of the three request registers.
- pos_err  output  1  sticky flag: position was seen not one-hot.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - car_req, up_req, dn_req all 0.
  - FSM to IDLE, so ud_mode=00.
  - pos_err=0.
  - Consequently all outputs are 0.
  - rst during motion drops all pending requests; no special handling.
- Set rule: on every cycle, req[f] <= req[f] | btn[f].
  - hall_up[FLOORS-1] and hall_dn[0] are masked to 0.
  - Latency: a button sampled at edge n shows in the lamp and in the needs after edge n. ud_mode follows one edge later.
- Floor-relative needs:
  - any[f] = car_req[f] | up_req[f] | dn_req[f].
  - up_need = OR of any[] strictly above the position bit.
  - down_need = OR of any[] strictly below the position bit.
  - Both are combinational from registers.
- Direction FSM (states IDLE, UP, DN). Transitions are evaluated only when mv2nxt=0 and opendoor=0; otherwise the state holds.
  - IDLE: up_need -> UP; else down_need -> DN; else stay. If both are set, UP wins.
  - UP: up_need=1 -> stay; else down_need -> DN; else -> IDLE.
  - DN: symmetric to UP.
- Stop mask allReq_reg[f]:
  - Always includes car_req[f].
  - Plus up_req[f] when the state is UP or IDLE.
  - Plus dn_req[f] when the state is DN or IDLE.
  - Plus the opposite hall call when no request lies ahead in the current direction. Example: in UP with up_need=0, dn_req[f] is included.
- Clear rule: while opendoor=1 at floor f = position:
  - Clear car_req[f].
  - Clear every hall request at f that is included in allReq_reg[f].
  - Clear has priority over set in the same cycle. A button pressed at the open floor is therefore absorbed.
- Position error: if position is not one-hot (zero or multiple bits):
  - pos_err <= 1 (sticky until rst).
  - up_need=down_need=0 and allReq_reg=0.
  - No clears, and the FSM holds.
- Boundaries:
  - At the top floor up_need is always 0; at the bottom floor down_need is always 0.
  - All buttons pressed at once: every bit latches with no loss.
  - Direction reversal never occurs while mv2nxt=1.

Decomposition:
- Shared package elevator_pkg:
  - FLOORS default.
  - UD_IDLE=2'b00, UD_UP=2'b01, UD_DN=2'b10. These are the same encodings the car state controller uses.
- One natural sub-module, floor_mask_calc (combinational). From position and a request vector it produces:
  - above/below masks;
  - onehot_ok;
  - any_above and any_below.

Test Plan:
- Reset, then car_btn=4'b1000 at position 0001 -> car_lamp=1000 next edge; up_need=1; ud_mode=01 one edge later; allReq_reg=1000.
- In UP at position 0010 with hall_dn[2] and car_req[3] pending -> allReq_reg=1000 (dn_req[2] excluded). After the car reaches 1000 and opendoor=1 -> car_req[3] cleared; ud_mode goes to 10; allReq_reg=0100.
- opendoor=1 at position 0100 while hall_up[2] is held high -> up_req[2] stays 0 (clear beats set).
- hall_up[3]=1 and hall_dn[0]=1 pressed -> up_lamp and dn_lamp remain 0000.
- Request below asserted while mv2nxt=1 in UP with none above -> ud_mode stays 01 until mv2nxt=0 and opendoor=0, then 10.
- position=4'b0110 -> pos_err=1 latched; up_need=down_need=0; requests retained. rst -> all cleared.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler and the car state
// controller: default floor count and the direction-mode encodings.
package elevator_pkg;

  localparam int FLOORS = 4;

  // Direction mode encodings, shared with the car state controller.
  typedef logic [1:0] ud_mode_t;
  localparam ud_mode_t UD_IDLE = 2'b00;
  localparam ud_mode_t UD_UP   = 2'b01;
  localparam ud_mode_t UD_DN   = 2'b10;

endpackage

// File: rtl/elevator_req_sched_floor_mask_calc.sv
// Floor-relative masks: which floors lie strictly above / below the one-hot
// car position, whether the position is a valid one-hot value, and whether
// any bit of a request vector lies above / below the car.
module floor_mask_calc #(
  parameter int FLOORS = 4
) (
  input  logic [FLOORS-1:0] position,
  input  logic [FLOORS-1:0] req,
  output logic [FLOORS-1:0] above_mask,
  output logic [FLOORS-1:0] below_mask,
  output logic              onehot_ok,
  output logic              any_above,
  output logic              any_below
);
  import elevator_pkg::*;

  // A floor is above the car when some position bit sits below it, and vice versa.
  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_mask
      if (gi == 0) begin : g_bot
        assign above_mask[gi] = 1'b0;
      end else begin : g_abv
        assign above_mask[gi] = |position[gi-1:0];
      end
      if (gi == FLOORS-1) begin : g_top
        assign below_mask[gi] = 1'b0;
      end else begin : g_blw
        assign below_mask[gi] = |position[FLOORS-1:gi+1];
      end
    end
  endgenerate

  // Zero or multiple position bits make every floor-relative answer meaningless.
  assign onehot_ok = (position != '0) && ((position & (position - 1'b1)) == '0);
  assign any_above = onehot_ok & (|(req & above_mask));
  assign any_below = onehot_ok & (|(req & below_mask));

endmodule

// File: rtl/elevator_req_sched.sv
// Elevator request scheduler: latches car and hall calls, clears the calls
// served at each door opening, runs the travel-direction FSM and produces the
// stop mask and up/down needs consumed by the car state controller.
module elevator_req_sched #(
  parameter int FLOORS = elevator_pkg::FLOORS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] car_btn,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic [FLOORS-1:0] position,
  input  logic              opendoor,
  input  logic              mv2nxt,
  output logic [FLOORS-1:0] allReq_reg,
  output logic              up_need,
  output logic              down_need,
  output logic [1:0]        ud_mode,
  output logic [FLOORS-1:0] car_lamp,
  output logic [FLOORS-1:0] up_lamp,
  output logic [FLOORS-1:0] dn_lamp,
  output logic              pos_err
);
  import elevator_pkg::*;

  logic [FLOORS-1:0] car_req_reg, car_req_next;
  logic [FLOORS-1:0] up_req_reg,  up_req_next;
  logic [FLOORS-1:0] dn_req_reg,  dn_req_next;
  logic [1:0]        state_reg,   state_next;
  logic              pos_err_reg, pos_err_next;

  logic [FLOORS-1:0] any_req;
  logic [FLOORS-1:0] above_mask, below_mask;
  logic              onehot_ok, any_above, any_below;
  logic              ahead_none, up_incl, dn_incl;
  logic [FLOORS-1:0] clr_mask, hall_up_ok, hall_dn_ok, stop_mask;

  assign any_req = car_req_reg | up_req_reg | dn_req_reg;

  // No up call exists at the top floor, no down call at the bottom floor.
  assign hall_up_ok = {1'b0, hall_up[FLOORS-2:0]};
  assign hall_dn_ok = {hall_dn[FLOORS-1:1], 1'b0};

  floor_mask_calc #(
    .FLOORS(FLOORS)
  ) u_mask (
    .position  (position),
    .req       (any_req),
    .above_mask(above_mask),
    .below_mask(below_mask),
    .onehot_ok (onehot_ok),
    .any_above (any_above),
    .any_below (any_below)
  );

  // Stop mask and clear mask: which hall calls count for the current direction.
  always_comb begin
    ahead_none = ~|(any_req & ((state_reg == UD_DN) ? below_mask : above_mask));
    // With nothing left ahead the car will turn around here, so the opposite
    // hall call is served too.
    up_incl    = (state_reg != UD_DN) | ahead_none;
    dn_incl    = (state_reg != UD_UP) | ahead_none;
    stop_mask  = '0;
    if (onehot_ok) begin
      stop_mask = car_req_reg
                | (up_req_reg & {FLOORS{up_incl}})
                | (dn_req_reg & {FLOORS{dn_incl}});
    end
    clr_mask = (opendoor && onehot_ok) ? position : '0;
  end

  // Request registers: set by buttons, cleared at the open floor (clear wins).
  always_comb begin
    car_req_next = (car_req_reg | car_btn)    & ~clr_mask;
    up_req_next  = (up_req_reg  | hall_up_ok) & ~(clr_mask & {FLOORS{up_incl}});
    dn_req_next  = (dn_req_reg  | hall_dn_ok) & ~(clr_mask & {FLOORS{dn_incl}});
    pos_err_next = pos_err_reg | ~onehot_ok;
  end

  // Direction FSM with hysteresis: only re-evaluated while parked, doors shut.
  always_comb begin
    state_next = state_reg;
    if (!mv2nxt && !opendoor && onehot_ok) begin
      case (state_reg)
        UD_IDLE: begin
          if (any_above)      state_next = UD_UP;
          else if (any_below) state_next = UD_DN;
        end
        UD_UP: begin
          if (!any_above) state_next = any_below ? UD_DN : UD_IDLE;
        end
        UD_DN: begin
          if (!any_below) state_next = any_above ? UD_UP : UD_IDLE;
        end
        default: state_next = UD_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      car_req_reg <= '0;
      up_req_reg  <= '0;
      dn_req_reg  <= '0;
      state_reg   <= UD_IDLE;
      pos_err_reg <= 1'b0;
    end else begin
      car_req_reg <= car_req_next;
      up_req_reg  <= up_req_next;
      dn_req_reg  <= dn_req_next;
      state_reg   <= state_next;
      pos_err_reg <= pos_err_next;
    end
  end

  assign allReq_reg = stop_mask;
  assign up_need    = any_above;
  assign down_need  = any_below;
  assign ud_mode    = state_reg;
  assign car_lamp   = car_req_reg;
  assign up_lamp    = up_req_reg;
  assign dn_lamp    = dn_req_reg;
  assign pos_err    = pos_err_reg;

endmodule

// File: tb/tb_elevator_req_sched.sv
// Directed bench for elevator_req_sched: a cycle-by-cycle vector table plus
// hand-written sequences for direction hysteresis and position errors.
module tb_elevator_req_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] car_btn, hall_up, hall_dn, position;
  logic       opendoor, mv2nxt;
  logic [3:0] allReq_reg, car_lamp, up_lamp, dn_lamp;
  logic       up_need, down_need, pos_err;
  logic [1:0] ud_mode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] car, hu, hd, pos;
    logic       od, mv;
    logic [3:0] e_stop;
    logic       e_un, e_dn;
    logic [1:0] e_ud;
    logic [3:0] e_car, e_upl, e_dnl;
    logic       e_perr;
  } vec_t;

  vec_t vecs[$];

  elevator_req_sched #(.FLOORS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .car_btn   (car_btn),
    .hall_up   (hall_up),
    .hall_dn   (hall_dn),
    .position  (position),
    .opendoor  (opendoor),
    .mv2nxt    (mv2nxt),
    .allReq_reg(allReq_reg),
    .up_need   (up_need),
    .down_need (down_need),
    .ud_mode   (ud_mode),
    .car_lamp  (car_lamp),
    .up_lamp   (up_lamp),
    .dn_lamp   (dn_lamp),
    .pos_err   (pos_err)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic [3:0] c, input logic [3:0] hu,
                         input logic [3:0] hd, input logic [3:0] p, input logic od,
                         input logic mv, input logic [3:0] es, input logic eu,
                         input logic ed, input logic [1:0] eud, input logic [3:0] ec,
                         input logic [3:0] eup, input logic [3:0] edn, input logic ep);
    vec_t v;
    v.rst = r; v.car = c; v.hu = hu; v.hd = hd; v.pos = p; v.od = od; v.mv = mv;
    v.e_stop = es; v.e_un = eu; v.e_dn = ed; v.e_ud = eud;
    v.e_car = ec; v.e_upl = eup; v.e_dnl = edn; v.e_perr = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string tag, input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %b expected %b", tag, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then compare all outputs.
  task automatic run_vec(input string tag, input vec_t v);
    rst = v.rst; car_btn = v.car; hall_up = v.hu; hall_dn = v.hd;
    position = v.pos; opendoor = v.od; mv2nxt = v.mv;
    @(posedge clk);
    #1;
    chk(tag, "allReq_reg", {4'b0, allReq_reg}, {4'b0, v.e_stop});
    chk(tag, "up_need",    {7'b0, up_need},    {7'b0, v.e_un});
    chk(tag, "down_need",  {7'b0, down_need},  {7'b0, v.e_dn});
    chk(tag, "ud_mode",    {6'b0, ud_mode},    {6'b0, v.e_ud});
    chk(tag, "car_lamp",   {4'b0, car_lamp},   {4'b0, v.e_car});
    chk(tag, "up_lamp",    {4'b0, up_lamp},    {4'b0, v.e_upl});
    chk(tag, "dn_lamp",    {4'b0, dn_lamp},    {4'b0, v.e_dnl});
    chk(tag, "pos_err",    {7'b0, pos_err},    {7'b0, v.e_perr});
    $display("%s: pos=%b od=%b mv=%b -> stop=%b un=%b dn=%b ud=%b car=%b up=%b dnl=%b perr=%b",
             tag, v.pos, v.od, v.mv, allReq_reg, up_need, down_need, ud_mode,
             car_lamp, up_lamp, dn_lamp, pos_err);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; car_btn = '0; hall_up = '0; hall_dn = '0;
    position = 4'b0001; opendoor = 1'b0; mv2nxt = 1'b0;

    //       rst car     hu      hd      pos     od mv  stop    un dn ud     car     upl     dnl     perr
    add_vec(1, 4'b0000,4'b0000,4'b0000,4'b0001,0,0, 4'b0000,0,0,2'b00,4'b0000,4'b0000,4'b0000,0); // reset
    add_vec(0, 4'b1000,4'b0000,4'b0000,4'b0001,0,0, 4'b1000,1,0,2'b00,4'b1000,4'b0000,4'b0000,0); // car call 3
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0001,0,0, 4'b1000,1,0,2'b01,4'b1000,4'b0000,4'b0000,0); // -> UP
    add_vec(0, 4'b0000,4'b0000,4'b0100,4'b0001,0,1, 4'b1000,1,0,2'b01,4'b1000,4'b0000,4'b0100,0); // hall dn 2
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0010,0,0, 4'b1000,1,0,2'b01,4'b1000,4'b0000,4'b0100,0); // dn[2] excluded
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0100,0,1, 4'b1000,1,0,2'b01,4'b1000,4'b0000,4'b0100,0); // pass floor 2
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b1000,1,0, 4'b0100,0,1,2'b01,4'b0000,4'b0000,4'b0100,0); // door at 3
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b1000,0,0, 4'b0100,0,1,2'b10,4'b0000,4'b0000,4'b0100,0); // -> DN
    add_vec(0, 4'b0000,4'b0100,4'b0000,4'b0100,1,0, 4'b0000,0,0,2'b10,4'b0000,4'b0000,4'b0000,0); // clear beats set
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0100,0,0, 4'b0000,0,0,2'b00,4'b0000,4'b0000,4'b0000,0); // -> IDLE
    add_vec(0, 4'b0000,4'b1000,4'b0001,4'b0100,0,0, 4'b0000,0,0,2'b00,4'b0000,4'b0000,4'b0000,0); // masked hall bits
    add_vec(0, 4'b1111,4'b1111,4'b1111,4'b0100,0,1, 4'b1111,1,1,2'b00,4'b1111,4'b0111,4'b1110,0); // all buttons
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0100,1,0, 4'b1011,1,1,2'b00,4'b1011,4'b0011,4'b1010,0); // idle door clears all at 2
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0100,0,0, 4'b1011,1,1,2'b01,4'b1011,4'b0011,4'b1010,0); // both needs: UP wins
    add_vec(1, 4'b0000,4'b0000,4'b0000,4'b0100,0,0, 4'b0000,0,0,2'b00,4'b0000,4'b0000,4'b0000,0); // reset drops all

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Hysteresis: a reversal request stays pending while the car is moving.
    vecs.delete();
    add_vec(0, 4'b1000,4'b0000,4'b0000,4'b0100,0,0, 4'b1000,1,0,2'b00,4'b1000,4'b0000,4'b0000,0);
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0100,0,0, 4'b1000,1,0,2'b01,4'b1000,4'b0000,4'b0000,0);
    add_vec(0, 4'b0001,4'b0000,4'b0000,4'b1000,1,0, 4'b0001,0,1,2'b01,4'b0001,4'b0000,4'b0000,0);
    for (int k = 0; k < 3; k++)
      add_vec(0, 4'b0000,4'b0000,4'b0000,4'b1000,0,1, 4'b0001,0,1,2'b01,4'b0001,4'b0000,4'b0000,0);
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b1000,0,0, 4'b0001,0,1,2'b10,4'b0001,4'b0000,4'b0000,0);
    // Position error: sticky flag, needs and stop mask suppressed, requests kept.
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b0110,0,0, 4'b0000,0,0,2'b10,4'b0001,4'b0000,4'b0000,1);
    add_vec(0, 4'b0000,4'b0000,4'b0000,4'b1000,0,0, 4'b0001,0,1,2'b10,4'b0001,4'b0000,4'b0000,1);
    add_vec(1, 4'b0000,4'b0000,4'b0000,4'b1000,0,0, 4'b0000,0,0,2'b00,4'b0000,4'b0000,4'b0000,0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec($sformatf("seq%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
